// File: rtl/mips_mem_pkg.sv
// Shared store-path types: access sizes, FIFO entry layout and occupancy states.
package mips_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int NUM_LANES  = 4;

    localparam logic [NUM_LANES-1:0] BE_ALL = 4'b1111;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    // One buffered write, already word-aligned and lane-replicated.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [NUM_LANES-1:0]  be;
    } store_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: replicates right-justified store data across
// byte lanes, builds byte enables and flags stores that break natural alignment.
module store_lane_align
    import mips_mem_pkg::*;
(
    input  mem_size_e                  size,
    input  logic [1:0]                 addr_lo,
    input  logic [MEM_DATA_W-1:0]      data,
    output logic [MEM_DATA_W-1:0]      wdata,
    output logic [NUM_LANES-1:0]       be,
    output logic                       misaligned
);

    // Decode size and low address bits into lane data, enables and alignment error.
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        wdata      = data;
        be         = '0;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            SIZE_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{data[15:0]}};
                misaligned = addr_lo[0];
            end
            SIZE_WORD: begin
                be         = BE_ALL;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer between the MEM stage and the data-memory write port: aligns
// core stores, queues up to DEPTH of them and drains them in order.
module store_align_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    output logic              misalign_err,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    store_entry_t             fifo_q [DEPTH];
    store_entry_t             fifo_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     misalign_err_q, misalign_err_d;

    store_entry_t             new_entry;
    store_entry_t             head;
    logic [DATA_W-1:0]        lane_wdata;
    logic [3:0]               lane_be;
    logic                     misaligned;
    occ_e                     occ;
    logic                     accept;
    logic                     enq;
    logic                     deq;

    store_lane_align u_lane_align (
        .size       (mem_size_e'(st_size)),
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .wdata      (lane_wdata),
        .be         (lane_be),
        .misaligned (misaligned)
    );

    // Classify occupancy from the count; EMPTY/FULL drive the handshakes.
    always_comb begin
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == CNT_W'(DEPTH)) begin
            occ = OCC_FULL;
        end else begin
            occ = OCC_PARTIAL;
        end
    end

    // Handshakes are registered-state only: a full buffer never accepts, even while draining.
    assign st_ready  = (occ != OCC_FULL) && !rst;
    assign mem_valid = (occ != OCC_EMPTY);
    assign busy      = mem_valid;

    assign accept = st_valid && st_ready;
    assign enq    = accept && !misaligned;
    assign deq    = mem_valid && mem_ready;

    assign new_entry = '{addr:  {st_addr[ADDR_W-1:2], 2'b00},
                         wdata: lane_wdata,
                         be:    lane_be};

    // Head fields are forced to zero when empty so stale storage never shows on the port.
    assign head      = fifo_q[rd_ptr_q];
    assign mem_addr  = mem_valid ? head.addr  : '0;
    assign mem_wdata = mem_valid ? head.wdata : '0;
    assign mem_be    = mem_valid ? head.be    : '0;

    assign misalign_err = misalign_err_q;

    // Next-state for storage, pointers, count and the rejected-store pulse.
    always_comb begin
        fifo_d         = fifo_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        misalign_err_d = accept && misaligned;
        if (enq) begin
            fifo_d[wr_ptr_q] = new_entry;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; reset discards all queued stores.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Entry storage written on enqueue.
    // NOTE: storage is not reset; count gates visibility, so its contents after reset are never observed.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
